tcdm_responder: RTL

TCDM_RESPONDER -- requirements
Module: tcdm_responder

---
 rtl/aes_package.sv | 30 +++
 rtl/hwpe_stream_intf_tcdm.sv | 17 +
 rtl/tcdm_rr_arbiter.sv | 45 ++++
 rtl/tcdm_responder.sv | 107 ++++++++++
 4 files changed

// File: rtl/aes_package.sv
// Shared TCDM bus widths, the request record and the byte-lane merge helper
// used by the responder and its testbench.
package aes_package;

    localparam int TCDM_DW = 32;
    localparam int TCDM_AW = 32;
    localparam int TCDM_BW = TCDM_DW / 8;

    typedef struct packed {
        logic [TCDM_AW-1:0] add;
        logic               wen;
        logic [TCDM_BW-1:0] be;
        logic [TCDM_DW-1:0] data;
    } tcdm_req_t;

    // Replace only the byte lanes whose enable is set.
    function automatic logic [TCDM_DW-1:0] merge_bytes(
        input logic [TCDM_DW-1:0] old_word,
        input logic [TCDM_DW-1:0] new_word,
        input logic [TCDM_BW-1:0] be
    );
        logic [TCDM_DW-1:0] res;
        res = old_word;
        for (int b = 0; b < TCDM_BW; b++) begin
            if (be[b]) res[8*b +: 8] = new_word[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/hwpe_stream_intf_tcdm.sv
// One TCDM master/slave link: request phase plus single-cycle read response.
interface hwpe_stream_intf_tcdm;
    import aes_package::*;

    logic               req;
    logic               gnt;
    logic [TCDM_AW-1:0] add;
    logic               wen;
    logic [TCDM_BW-1:0] be;
    logic [TCDM_DW-1:0] data;
    logic [TCDM_DW-1:0] r_data;
    logic               r_valid;

    modport master (output req, add, wen, be, data, input  gnt, r_data, r_valid);
    modport slave  (input  req, add, wen, be, data, output gnt, r_data, r_valid);

endinterface

// File: rtl/tcdm_rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts at rr_ptr, pointer moves
// past the winner. A stall cycle or reset suppresses every grant.
module tcdm_rr_arbiter #(
    parameter int MP = 4
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic [MP-1:0] req,
    input  logic          stall,
    output logic [MP-1:0] gnt
);

    localparam int PW = (MP > 1) ? $clog2(MP) : 1;

    logic [PW-1:0] rr_ptr_q;
    logic [PW-1:0] rr_ptr_d;

    always_comb begin
        logic found;
        int   idx;
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        gnt      = '0;
        rr_ptr_d = rr_ptr_q;
        found    = 1'b0;
        idx      = 0;
        if (rst_ni && !stall) begin
            for (int k = 0; k < MP; k++) begin
                idx = int'(rr_ptr_q) + k;
                if (idx >= MP) idx = idx - MP;
                if (!found && req[idx]) begin
                    found    = 1'b1;
                    gnt[idx] = 1'b1;
                    rr_ptr_d = (idx == MP - 1) ? '0 : PW'(idx + 1);
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: state registers use non-blocking assignments so all flops update together.
        if (!rst_ni) rr_ptr_q <= '0;
        else         rr_ptr_q <= rr_ptr_d;
    end

endmodule

// File: rtl/tcdm_responder.sv
// Single-ported TCDM memory model serving MP master ports through a
// round-robin arbiter with optional periodic grant stalls.
module tcdm_responder
    import aes_package::*;
#(
    parameter int MP               = 4,
    parameter int DEPTH_WORDS      = 1024,
    parameter int GNT_STALL_PERIOD = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  test_mode_i,
    hwpe_stream_intf_tcdm.slave   tcdm [MP-1:0]
);

    localparam int IW = $clog2(DEPTH_WORDS);

    logic [MP-1:0]      req;
    logic [MP-1:0]      gnt;
    logic [MP-1:0]      wen;
    logic [TCDM_AW-1:0] add   [MP];
    logic [TCDM_BW-1:0] be    [MP];
    logic [TCDM_DW-1:0] wdata [MP];

    logic [MP-1:0]      r_valid_q;
    logic [TCDM_DW-1:0] r_data_q [MP];

    for (genvar g = 0; g < MP; g++) begin : g_port
        assign req[g]          = tcdm[g].req;
        assign add[g]          = tcdm[g].add;
        assign wen[g]          = tcdm[g].wen;
        assign be[g]           = tcdm[g].be;
        assign wdata[g]        = tcdm[g].data;
        assign tcdm[g].gnt     = gnt[g];
        assign tcdm[g].r_valid = r_valid_q[g];
        assign tcdm[g].r_data  = r_data_q[g];
    end

    logic stall;

    if (GNT_STALL_PERIOD > 0) begin : g_stall
        localparam int SW = (GNT_STALL_PERIOD > 1) ? $clog2(GNT_STALL_PERIOD) : 1;
        logic [SW-1:0] stall_cnt_q;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni)                                    stall_cnt_q <= '0;
            else if (stall_cnt_q == SW'(GNT_STALL_PERIOD - 1)) stall_cnt_q <= '0;
            else                                            stall_cnt_q <= stall_cnt_q + 1'b1;
        end

        assign stall = (stall_cnt_q == SW'(GNT_STALL_PERIOD - 1));
    end else begin : g_no_stall
        assign stall = 1'b0;
    end

    tcdm_rr_arbiter #(
        .MP (MP)
    ) u_arbiter (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .req    (req),
        .stall  (stall),
        .gnt    (gnt)
    );

    // Gather the winning port's request; gnt is one-hot so at most one term fires.
    tcdm_req_t sel;

    always_comb begin
        sel = '0;
        for (int p = 0; p < MP; p++) begin
            if (gnt[p]) begin
                sel.add  = add[p];
                sel.wen  = wen[p];
                sel.be   = be[p];
                sel.data = wdata[p];
            end
        end
    end

    logic [IW-1:0] word_idx;
    assign word_idx = sel.add[IW+1:2];

    // NOTE: the storage array has no reset; its contents are defined only by writes.
    logic [TCDM_DW-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk_i) begin
        if (|gnt && !sel.wen) mem[word_idx] <= merge_bytes(mem[word_idx], sel.data, sel.be);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid_q <= '0;
            for (int p = 0; p < MP; p++) r_data_q[p] <= '0;
        end else begin
            r_valid_q <= gnt & {MP{sel.wen}};
            for (int p = 0; p < MP; p++) begin
                if (gnt[p] && sel.wen) r_data_q[p] <= mem[word_idx];
            end
        end
    end

    // Address bits outside the word index and the test-mode strap drive nothing.
    logic unused_bits;
    assign unused_bits = ^{test_mode_i, sel.add[TCDM_AW-1:IW+2], sel.add[1:0]};

endmodule
